// File: rtl/dp_sequencer.sv
// Multi-cycle sequencer for ARM data-processing instructions (IDLE/DECODE/EXECUTE/WRITEBACK).
// Define COND_EXEC_EN to enable condition-code evaluation; otherwise every cond is treated as AL.
module dp_sequencer #(
  parameter int REG_NUM_W = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [31:0]          instr,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic [3:0]           nzcv,
  output logic [REG_NUM_W-1:0] read_reg_num1,
  output logic [REG_NUM_W-1:0] read_reg_num2,
  output logic [REG_NUM_W-1:0] write_reg,
  output logic [3:0]           alu_control,
  output logic                 regwrite,
  output logic [3:0]           flags,
  output logic                 done,
  output logic                 cond_fail,
  output logic                 illegal
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK
  } state_e;

  // Only the instruction fields the sequencer actually uses are latched.
  typedef struct packed {
`ifdef COND_EXEC_EN
    logic [3:0] cond;
`endif
    logic [1:0] op_class;
    logic       imm;
    logic [3:0] opcode;
    logic       s_bit;
    logic [3:0] rn;
    logic [3:0] rd;
    logic [3:0] rm;
  } dec_t;

  state_e     state_q, state_d;
  dec_t       dec_q, dec_d;
  logic [3:0] flags_q, flags_d;
  logic       illegal_q, illegal_d;
  logic       cond_fail_q, cond_fail_d;

  logic       dec_illegal;
  logic       dec_pass;
  logic       unused_instr_bits;

`ifdef COND_EXEC_EN
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cond)
      4'h0:    cond_pass = z;
      4'h1:    cond_pass = !z;
      4'h2:    cond_pass = c;
      4'h3:    cond_pass = !c;
      4'h4:    cond_pass = n;
      4'h5:    cond_pass = !n;
      4'h6:    cond_pass = v;
      4'h7:    cond_pass = !v;
      4'h8:    cond_pass = c && !z;
      4'h9:    cond_pass = !c || z;
      4'hA:    cond_pass = (n == v);
      4'hB:    cond_pass = (n != v);
      4'hC:    cond_pass = !z && (n == v);
      4'hD:    cond_pass = z || (n != v);
      4'hE:    cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

  assign unused_instr_bits = ^instr[11:4];
  assign dec_illegal = (dec_q.op_class != 2'b00) || dec_q.imm || (dec_q.cond == 4'hF);
  assign dec_pass    = cond_pass(dec_q.cond, flags_q);
`else
  assign unused_instr_bits = ^{instr[31:28], instr[11:4]};
  assign dec_illegal = (dec_q.op_class != 2'b00) || dec_q.imm;
  assign dec_pass    = 1'b1;
`endif

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    dec_d       = dec_q;
    flags_d     = flags_q;
    illegal_d   = illegal_q;
    cond_fail_d = cond_fail_q;
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
`ifdef COND_EXEC_EN
          dec_d.cond = instr[31:28];
`endif
          dec_d.op_class = instr[27:26];
          dec_d.imm      = instr[25];
          dec_d.opcode   = instr[24:21];
          dec_d.s_bit    = instr[20];
          dec_d.rn       = instr[19:16];
          dec_d.rd       = instr[15:12];
          dec_d.rm       = instr[3:0];
          state_d        = S_DECODE;
        end
      end
      S_DECODE: begin
        illegal_d   = dec_illegal;
        cond_fail_d = !dec_illegal && !dec_pass;
        state_d     = (dec_illegal || !dec_pass) ? S_WRITEBACK : S_EXECUTE;
      end
      S_EXECUTE: begin
        if (dec_q.s_bit) flags_d = nzcv;
        state_d = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        illegal_d   = 1'b0;
        cond_fail_d = 1'b0;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      dec_q       <= '0;
      flags_q     <= 4'b0000;
      illegal_q   <= 1'b0;
      cond_fail_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dec_q       <= dec_d;
      flags_q     <= flags_d;
      illegal_q   <= illegal_d;
      cond_fail_q <= cond_fail_d;
    end
  end

  logic active;
  logic in_exec_wb;

  assign active     = (state_q != S_IDLE);
  assign in_exec_wb = (state_q == S_EXECUTE) || (state_q == S_WRITEBACK);

  assign instr_ready   = (state_q == S_IDLE);
  assign read_reg_num1 = active ? REG_NUM_W'(dec_q.rn) : '0;
  assign read_reg_num2 = active ? REG_NUM_W'(dec_q.rm) : '0;
  assign write_reg     = active ? REG_NUM_W'(dec_q.rd) : '0;
  assign alu_control   = in_exec_wb ? dec_q.opcode : 4'b0000;
  assign flags         = flags_q;
  assign done          = (state_q == S_WRITEBACK);
  // Compare-class opcodes (TST/TEQ/CMP/CMN) only affect flags.
  assign regwrite      = done && !illegal_q && !cond_fail_q && (dec_q.opcode[3:2] != 2'b10);
  assign illegal       = done && illegal_q;
  assign cond_fail     = done && cond_fail_q;

endmodule

// File: tb/tb_dp_sequencer.sv
// Self-checking bench for dp_sequencer: expected results are queued at issue time and
// compared when done pulses. Honours COND_EXEC_EN in the same way as the design.
module tb_dp_sequencer;
  localparam int RW = 5;

  logic          clock;
  logic          reset;
  logic [31:0]   instr;
  logic          instr_valid;
  logic          instr_ready;
  logic [3:0]    nzcv;
  logic [RW-1:0] read_reg_num1;
  logic [RW-1:0] read_reg_num2;
  logic [RW-1:0] write_reg;
  logic [3:0]    alu_control;
  logic          regwrite;
  logic [3:0]    flags;
  logic          done;
  logic          cond_fail;
  logic          illegal;

  int         checks = 0;
  int         failures = 0;
  logic [3:0] model_flags = 4'b0000;

  typedef struct {
    logic [RW-1:0] rn, rm, rd;
    logic [3:0]    alu;
    logic [3:0]    flags;
    logic          rw, cf, il;
    int            lat;
  } exp_t;

  exp_t sb[$];

  dp_sequencer #(.REG_NUM_W(RW)) dut (
    .clock         (clock),
    .reset         (reset),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .nzcv          (nzcv),
    .read_reg_num1 (read_reg_num1),
    .read_reg_num2 (read_reg_num2),
    .write_reg     (write_reg),
    .alu_control   (alu_control),
    .regwrite      (regwrite),
    .flags         (flags),
    .done          (done),
    .cond_fail     (cond_fail),
    .illegal       (illegal)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

`ifdef COND_EXEC_EN
  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'h0: return z;
      4'h1: return ~z;
      4'h2: return cy;
      4'h3: return ~cy;
      4'h4: return n;
      4'h5: return ~n;
      4'h6: return v;
      4'h7: return ~v;
      4'h8: return cy & ~z;
      4'h9: return ~cy | z;
      4'hA: return ~(n ^ v);
      4'hB: return n ^ v;
      4'hC: return ~z & ~(n ^ v);
      4'hD: return z | (n ^ v);
      default: return 1'b1;
    endcase
  endfunction
`endif

  function automatic exp_t model(input logic [31:0] w, input logic [3:0] nz);
    exp_t e;
    logic il, pass, exec;
    il   = (w[27:26] != 2'b00) || w[25];
    pass = 1'b1;
`ifdef COND_EXEC_EN
    if (w[31:28] == 4'hF) il = 1'b1;
    else pass = cond_ok(w[31:28], model_flags);
`endif
    exec    = !il && pass;
    e.rn    = RW'(w[19:16]);
    e.rm    = RW'(w[3:0]);
    e.rd    = RW'(w[15:12]);
    e.alu   = w[24:21];
    e.il    = il;
    e.cf    = !il && !pass;
    e.rw    = exec && !(w[24:21] >= 4'd8 && w[24:21] <= 4'd11);
    e.flags = (exec && w[20]) ? nz : model_flags;
    e.lat   = exec ? 3 : 2;
    return e;
  endfunction

  // Starts and ends just after a falling edge with the DUT in IDLE.
  task automatic run_instr(input logic [31:0] word, input logic [3:0] nz, input string tag);
    exp_t e;
    int   cyc;
    sb.push_back(model(word, nz));
    instr = word; instr_valid = 1'b1; nzcv = nz;
    checks++;
    if (instr_ready !== 1'b1) begin
      failures++; $display("FAIL %s ready: got %b expected 1", tag, instr_ready);
    end
    @(posedge clock); @(negedge clock);
    instr_valid = 1'b0; instr = $urandom;
    e = sb[0];
    checks++;
    if (read_reg_num1 !== e.rn || read_reg_num2 !== e.rm || write_reg !== e.rd) begin
      failures++;
      $display("FAIL %s decode_regs: got %0d/%0d/%0d expected %0d/%0d/%0d", tag,
               read_reg_num1, read_reg_num2, write_reg, e.rn, e.rm, e.rd);
    end
    cyc = 1;
    while (done !== 1'b1 && cyc < 6) begin
      checks++;
      if (regwrite !== 1'b0) begin
        failures++; $display("FAIL %s early_regwrite: got %b expected 0 in cycle %0d", tag, regwrite, cyc);
      end
      @(negedge clock); cyc++;
    end
    checks++;
    if (done !== 1'b1) begin
      failures++; $display("FAIL %s done_timeout: got done=%b expected 1 within 6 cycles", tag, done);
      e = sb.pop_front();
    end else begin
      e = sb.pop_front();
      checks++;
      if (cyc != e.lat) begin
        failures++; $display("FAIL %s latency: got %0d expected %0d", tag, cyc, e.lat);
      end
      checks++;
      if (regwrite !== e.rw) begin
        failures++; $display("FAIL %s regwrite: got %b expected %b", tag, regwrite, e.rw);
      end
      checks++;
      if (illegal !== e.il || cond_fail !== e.cf) begin
        failures++;
        $display("FAIL %s qualifiers: got illegal=%b cond_fail=%b expected %b %b", tag, illegal, cond_fail, e.il, e.cf);
      end
      checks++;
      if (alu_control !== e.alu || write_reg !== e.rd) begin
        failures++;
        $display("FAIL %s wb_outputs: got alu=%h wr=%0d expected %h %0d", tag, alu_control, write_reg, e.alu, e.rd);
      end
      @(negedge clock);
      checks++;
      if (done !== 1'b0 || instr_ready !== 1'b1 || write_reg !== '0 || alu_control !== 4'h0) begin
        failures++;
        $display("FAIL %s idle_return: got done=%b ready=%b wr=%0d alu=%h expected 0 1 0 0", tag,
                 done, instr_ready, write_reg, alu_control);
      end
      checks++;
      if (flags !== e.flags) begin
        failures++; $display("FAIL %s flags: got %b expected %b", tag, flags, e.flags);
      end
    end
    model_flags = e.flags;
  endtask

  task automatic test_reset();
    reset = 1'b1; instr_valid = 1'b0; instr = '0; nzcv = 4'h0;
    @(posedge clock); @(negedge clock);
    checks++;
    if (instr_ready !== 1'b1 || done !== 1'b0 || regwrite !== 1'b0 || cond_fail !== 1'b0 || illegal !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got ready=%b done=%b rw=%b cf=%b il=%b expected 1 0 0 0 0",
               instr_ready, done, regwrite, cond_fail, illegal);
    end
    checks++;
    if (read_reg_num1 !== '0 || read_reg_num2 !== '0 || write_reg !== '0 || alu_control !== 4'h0 || flags !== 4'h0) begin
      failures++;
      $display("FAIL reset_data: got rn=%0d rm=%0d wr=%0d alu=%h flags=%b expected all 0",
               read_reg_num1, read_reg_num2, write_reg, alu_control, flags);
    end
    reset = 1'b0;
    model_flags = 4'b0000;
  endtask

  task automatic test_add();
    run_instr(32'hE081_2003, 4'b1111, "add");
  endtask

  task automatic test_cmp();
    run_instr(32'hE151_0002, 4'b0110, "cmp");
  endtask

  task automatic test_cond();
    run_instr(32'h1081_2003, 4'b0000, "addne");
    run_instr(32'h0081_2003, 4'b0000, "addeq");
    run_instr(32'hF081_2003, 4'b0000, "cond_1111");
  endtask

  task automatic test_illegal();
    run_instr(32'hE291_2003, 4'b1001, "imm_bit");
    run_instr(32'hE481_2003, 4'b1001, "class_01");
  endtask

  task automatic test_back_to_back();
    logic [31:0] w;
    for (int i = 0; i < 12; i++) begin
      w = {$urandom_range(15, 0) % 16 == 15 ? 4'hE : 4'($urandom_range(14, 0)), 2'b00, 1'b0,
           4'($urandom_range(15, 0)), 1'($urandom_range(1, 0)), 4'($urandom_range(15, 0)),
           4'($urandom_range(15, 0)), 8'h00, 4'($urandom_range(15, 0))};
      run_instr(w, 4'($urandom_range(15, 0)), "b2b");
    end
  endtask

  task automatic test_reset_mid();
    int n;
    instr = 32'hE091_2003; instr_valid = 1'b1; nzcv = 4'b1111;
    @(posedge clock); @(negedge clock);
    @(posedge clock); @(negedge clock);
    checks++;
    if (alu_control !== 4'b0100 || instr_ready !== 1'b0) begin
      failures++; $display("FAIL rmid_execute: got alu=%h ready=%b expected 4 0", alu_control, instr_ready);
    end
    reset = 1'b1;
    @(posedge clock); @(negedge clock);
    checks++;
    if (instr_ready !== 1'b1 || done !== 1'b0 || regwrite !== 1'b0 || flags !== 4'h0) begin
      failures++;
      $display("FAIL rmid_reset: got ready=%b done=%b rw=%b flags=%b expected 1 0 0 0000",
               instr_ready, done, regwrite, flags);
    end
    model_flags = 4'b0000;
    reset = 1'b0;
    instr = 32'hE081_5003;
    @(posedge clock); @(negedge clock);
    checks++;
    if (instr_ready !== 1'b0 || write_reg !== RW'(5)) begin
      failures++; $display("FAIL rmid_accept: got ready=%b wr=%0d expected 0 5", instr_ready, write_reg);
    end
    instr_valid = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 6) begin
      @(negedge clock); n++;
    end
    checks++;
    if (done !== 1'b1 || regwrite !== 1'b1 || n != 2) begin
      failures++;
      $display("FAIL rmid_complete: got done=%b rw=%b after %0d cycles expected 1 1 after 2", done, regwrite, n);
    end
    @(negedge clock);
    checks++;
    if (flags !== 4'h0 || instr_ready !== 1'b1) begin
      failures++; $display("FAIL rmid_flags: got flags=%b ready=%b expected 0000 1", flags, instr_ready);
    end
  endtask

  initial begin
    reset = 1'b1; instr_valid = 1'b0; instr = '0; nzcv = 4'h0;
    @(negedge clock);
    test_reset();
    test_add();
    test_cmp();
    test_cond();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    test_add();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
